// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver
// Scans a double-buffered ROWS x COLS frame onto an LED matrix: one-hot
// active-high row enables and active-low column lines, with a blank period at
// the start of every row slot. A newly loaded frame becomes visible only at
// the frame boundary (last row -> row 0), so a frame is never shown torn.
//
// Optional feature macro: BRIGHTNESS_PWM_EN
//   Adds a 4-bit brightness input. Within each ON phase the columns are gated
//   by a 4-bit PWM counter (restarted at ON entry). Brightness is sampled at
//   ON entry; 15 = full duty, 0 = 1/16 duty.

module led_matrix_scan_driver #(
    parameter int ROWS  = 5,
    parameter int COLS  = 7,
    parameter int SLOT  = 50000,
    parameter int BLANK = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS*COLS-1:0] frame_in,
    input  logic                 load,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]           brightness,
`endif
    output logic                 load_ack,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_n,
    output logic                 frame_sync
);

    localparam int CW = 20;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                 state_q, state_nxt;
    logic [CW-1:0]          cnt_q, cnt_nxt;
    logic [RW-1:0]          row_q, row_nxt;
    logic                   run_q;        // low until the first edge after reset
    logic                   boundary;     // ON(last row) -> BLANK(row 0) edge
    logic                   pend_flag_q;
    logic [ROWS*COLS-1:0]   pending_q;
    logic [ROWS*COLS-1:0]   active_q;
    logic [ROWS-1:0]        row_sel_nxt;
    logic [COLS-1:0]        col_n_nxt;
    logic                   pwm_ok;       // column gate for the coming cycle

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]             pwm_q, pwm_nxt;
    logic [3:0]             bright_q, bright_nxt;
    logic                   on_entry;
`endif

    // Next-state, slot counter, row index and next registered outputs.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + CW'(1);
        row_nxt   = row_q;
        boundary  = 1'b0;

        if (!run_q) begin
            // The first edge after reset starts row 0's slot at count 0.
            cnt_nxt = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CW'(BLANK - 1)) state_nxt = ST_ON;
                end
                ST_ON: begin
                    if (cnt_q == CW'(SLOT - 1)) begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_nxt  = '0;
                            boundary = 1'b1;
                        end else begin
                            row_nxt = row_q + RW'(1);
                        end
                    end
                end
                default: state_nxt = ST_BLANK;
            endcase
        end

`ifdef BRIGHTNESS_PWM_EN
        on_entry   = (state_q == ST_BLANK) && (state_nxt == ST_ON);
        pwm_nxt    = pwm_q;
        bright_nxt = bright_q;
        if (on_entry) begin
            pwm_nxt    = '0;
            bright_nxt = brightness;
        end else if (state_q == ST_ON) begin
            pwm_nxt = pwm_q + 4'd1;
        end
        pwm_ok = (pwm_nxt <= bright_nxt);
`else
        pwm_ok = 1'b1;
`endif

        // Outputs are computed from the next state so that, once registered,
        // they line up with the counter value they belong to. The active
        // buffer only changes on the edge into BLANK, so it is stable here
        // whenever the next state is ON.
        row_sel_nxt = '0;
        col_n_nxt   = '1;
        if (state_nxt == ST_ON) begin
            row_sel_nxt = ROWS'(1) << row_nxt;
            if (pwm_ok) col_n_nxt = ~active_q[int'(row_nxt)*COLS +: COLS];
        end
    end

    // State register, frame buffers, load handshake and registered outputs.
    // NOTE: non-blocking assignments throughout, so every register samples
    // pre-edge values regardless of statement order; the one intentional
    // ordering is pend_flag_q, where a load on the swap edge must win.
    // NOTE: the frame buffers are reset too, so a reset always shows a dark
    // matrix instead of stale or power-up contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            row_q       <= '0;
            run_q       <= 1'b0;
            pend_flag_q <= 1'b0;
            pending_q   <= '0;
            active_q    <= '0;
            load_ack    <= 1'b0;
            row_sel     <= '0;
            col_n       <= '1;
            frame_sync  <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
            pwm_q       <= '0;
            bright_q    <= '0;
`endif
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            row_q      <= row_nxt;
            run_q      <= 1'b1;
            row_sel    <= row_sel_nxt;
            col_n      <= col_n_nxt;
            frame_sync <= !run_q || boundary;
            load_ack   <= load;
`ifdef BRIGHTNESS_PWM_EN
            pwm_q      <= pwm_nxt;
            bright_q   <= bright_nxt;
`endif
            // Swap uses the pre-edge pending contents; a coincident load then
            // refills pending and keeps the flag set for the next frame.
            if (boundary && pend_flag_q) begin
                active_q    <= pending_q;
                pend_flag_q <= 1'b0;
            end
            if (load) begin
                pending_q   <= frame_in;
                pend_flag_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Testbench for led_matrix_scan_driver with SLOT=8, BLANK=2 (frame = 40 cycles).
// Table-driven frame loads plus hand-written sequences for tear-free swap,
// load/swap collision, back-to-back loads and reset mid-slot.

module tb_led_matrix_scan_driver;

    localparam int ROWS  = 5;
    localparam int COLS  = 7;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ROWS * SLOT;

    // Frames and their hand-computed active-low column patterns per row.
    localparam logic [34:0] F_ZERO = 35'h0;
    localparam logic [34:0] X_ZERO = 35'h7_FFFF_FFFF;
    localparam logic [34:0] F_B = {7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    localparam logic [34:0] X_B = {7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F};
    localparam logic [34:0] F_X = {7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F};
    localparam logic [34:0] X_X = {7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00};
    localparam logic [34:0] F_C = {7'h0F, 7'h0F, 7'h0F, 7'h0F, 7'h0F};
    localparam logic [34:0] X_C = {7'h70, 7'h70, 7'h70, 7'h70, 7'h70};
    localparam logic [34:0] F_D = {7'h33, 7'h33, 7'h33, 7'h33, 7'h33};
    localparam logic [34:0] F_E = {7'h18, 7'h24, 7'h42, 7'h24, 7'h18};
    localparam logic [34:0] X_E = {7'h67, 7'h5B, 7'h3D, 7'h5B, 7'h67};

    typedef struct packed {
        logic [34:0] frame;
        logic [34:0] exp_col_n;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [ROWS*COLS-1:0] frame_in = '0;
    logic                 load = 1'b0;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]           brightness = 4'hF;
`endif
    logic                 load_ack;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_n;
    logic                 frame_sync;

    int n_cmp = 0;
    int n_err = 0;

    led_matrix_scan_driver #(
        .ROWS(ROWS), .COLS(COLS), .SLOT(SLOT), .BLANK(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_in(frame_in),
        .load(load),
`ifdef BRIGHTNESS_PWM_EN
        .brightness(brightness),
`endif
        .load_ack(load_ack),
        .row_sel(row_sel),
        .col_n(col_n),
        .frame_sync(frame_sync)
    );

    // 10-unit clock; rising edges at 5, 15, ...; sampling on falling edges.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Checks cycles k0..k1 of a frame; the current sample must be cycle k0.
    task automatic check_range(input string tag, input logic [34:0] exp_col_n,
                               input int k0, input int k1);
        logic [12:0] exp;
        int r, p;
        for (int k = k0; k <= k1; k++) begin
            if (k != k0) @(negedge clk);
            r = k / SLOT;
            p = k % SLOT;
            if (p < BLANK) exp = {5'b0, 7'h7F, 1'b0};
            else           exp = {5'b1 << r, exp_col_n[r*COLS +: COLS], 1'b0};
            exp[0] = (k == 0);
            check($sformatf("%s k=%0d {row_sel,col_n,sync}", tag, k),
                  64'({row_sel, col_n, frame_sync}), 64'(exp));
        end
    endtask

    // Bounded wait for the next frame_sync sample; always advances at least once.
    task automatic wait_sync(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_sync && n < 2 * FRAME);
        if (!frame_sync) check($sformatf("%s sync timeout", tag), 64'(0), 64'(1));
    endtask

    task automatic do_load(input string tag, input logic [34:0] f);
        @(negedge clk);
        load = 1'b1;
        frame_in = f;
        @(negedge clk);
        load = 1'b0;
        check({tag, " load_ack pulse"}, 64'(load_ack), 64'(1));
        @(negedge clk);
        check({tag, " load_ack drop"}, 64'(load_ack), 64'(0));
    endtask

    vec_t vecs [3];

    initial begin
        vecs[0] = '{frame: 35'h1_0101_0101, exp_col_n: {7'h6F, 7'h77, 7'h7B, 7'h7D, 7'h7E}};
        vecs[1] = '{frame: 35'h7_FFFF_FFFF, exp_col_n: 35'h0};
        vecs[2] = '{frame: {7'h41, 7'h00, 7'h7F, 7'h2A, 7'h55},
                    exp_col_n: {7'h3E, 7'h7F, 7'h00, 7'h55, 7'h2A}};

        // Reset state.
        #1 rst = 1'b1;
        step(2);
        check("reset row_sel", 64'(row_sel), 64'(0));
        check("reset col_n", 64'(col_n), 64'(7'h7F));
        check("reset load_ack", 64'(load_ack), 64'(0));
        check("reset frame_sync", 64'(frame_sync), 64'(0));
        rst = 1'b0;

        // First cycle after release is row 0 slot start; empty frame shown.
        @(negedge clk);
        check_range("post-reset", X_ZERO, 0, FRAME - 1);

        // Table: load each frame, then the whole next frame must show it.
        for (int v = 0; v < 3; v++) begin
            do_load($sformatf("vec%0d", v), vecs[v].frame);
            wait_sync($sformatf("vec%0d", v));
            check_range($sformatf("vec%0d", v), vecs[v].exp_col_n, 0, FRAME - 1);
        end

        // Tear-free: load B at the first ON cycle of row 2 (k=18).
        wait_sync("tear");
        step(18);
        load = 1'b1;
        frame_in = F_B;
        @(negedge clk);
        load = 1'b0;
        check("tear load_ack", 64'(load_ack), 64'(1));
        check_range("tear old", vecs[2].exp_col_n, 19, FRAME - 1);
        @(negedge clk);
        check_range("tear new", X_B, 0, FRAME - 1);

        // Collision: X pending, C loaded on the boundary edge.
        step(6);                 // k=5
        load = 1'b1;
        frame_in = F_X;
        @(negedge clk);          // k=6
        load = 1'b0;
        check("coll X ack", 64'(load_ack), 64'(1));
        step(33);                // k=39
        load = 1'b1;
        frame_in = F_C;
        @(negedge clk);          // next frame k=0
        load = 1'b0;
        check("coll C ack", 64'(load_ack), 64'(1));
        check_range("coll X", X_X, 0, FRAME - 1);
        @(negedge clk);
        check_range("coll C", X_C, 0, FRAME - 1);

        // Back-to-back loads D then E: two acks, only E shown.
        step(11);                // k=10
        load = 1'b1;
        frame_in = F_D;
        @(negedge clk);          // k=11
        frame_in = F_E;
        check("b2b ack D", 64'(load_ack), 64'(1));
        @(negedge clk);          // k=12
        load = 1'b0;
        check("b2b ack E", 64'(load_ack), 64'(1));
        @(negedge clk);          // k=13
        check("b2b ack drop", 64'(load_ack), 64'(0));
        step(27);                // next frame k=0
        check_range("b2b E", X_E, 0, FRAME - 1);

        // Reset mid-ON (row 2, k=20) with a load in flight.
        step(21);
        rst = 1'b1;
        load = 1'b1;
        frame_in = F_C;
        #1;
        check("midrst row_sel", 64'(row_sel), 64'(0));
        check("midrst col_n", 64'(col_n), 64'(7'h7F));
        check("midrst frame_sync", 64'(frame_sync), 64'(0));
        step(2);
        load = 1'b0;
        check("midrst load_ack", 64'(load_ack), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("midrst no ack", 64'(load_ack), 64'(0));
        check_range("midrst cleared", X_ZERO, 0, FRAME - 1);
        wait_sync("midrst period");
        check_range("midrst next", X_ZERO, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan_driver.md
Name: led_matrix_scan_driver

Overview:
Downstream stage of the row-pattern bank/demux path: takes a complete 5x7 frame (one 7-bit column pattern per row) and time-multiplexes it onto the physical LED matrix. Drives one-hot row enables and active-low column lines. Double-buffered frame storage with a load handshake, a per-row dead time to prevent ghosting, and a frame-boundary swap so the display never shows a torn frame.

Parameters:
ROWS, 5, number of matrix rows scanned.
COLS, 7, number of column lines per row.
SLOT, 50000, clk cycles per row slot (blank + on); legal range BLANK+2 .. 2^20-1.
BLANK, 64, clk cycles at the start of each slot with all rows/columns off; must be >= 1.

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
frame_in  in  ROWS*COLS  frame data; bits [r*COLS+COLS-1 : r*COLS] = pattern of row r, bit c = 1 means LED (r,c) lit.
load  in  1  capture request; frame_in sampled on any clk edge with load=1.
load_ack  out  1  one-cycle pulse, the cycle after a capture.
row_sel  out  ROWS  one-hot row enable, active-high; all zero when blanked.
col_n  out  COLS  column drive, active-low (0 = LED on).
frame_sync  out  1  one-cycle pulse at the start of each row-0 slot.

Behaviour:
- Reset (async, rst=1): row_sel=0, col_n=all 1s, load_ack=0, frame_sync=0, active buffer=0, pending buffer=0, pending flag=0, row index=0, slot counter=0, state=BLANK.
- Two buffers: pending (written by load) and active (displayed). Load never writes active directly.
- Load: on edge with load=1, pending<=frame_in, pending flag<=1; load_ack=1 next cycle only. Back-to-back loads each capture and each ack; last one wins.
- FSM, two states, slot counter counts 0..SLOT-1:
  - BLANK: counter 0..BLANK-1; row_sel=0, col_n=all 1s. At counter=BLANK-1 -> ON.
  - ON: counter BLANK..SLOT-1; row_sel=1<<row, col_n=~active[row]. At counter=SLOT-1 -> BLANK, counter<=0, row<=row+1, wrap ROWS-1 -> 0.
- Outputs are registered: row_sel/col_n reflect the state they belong to in the same cycle as that counter value (no extra lag vs. counter).
- Frame boundary = transition ON(row ROWS-1) -> BLANK(row 0). On that edge: if pending flag=1, active<=pending and pending flag<=0; frame_sync=1 during the first BLANK cycle of row 0.
- Simultaneous load and swap on the same edge: swap uses the old pending contents; new frame_in goes to pending, pending flag stays 1 (shown next frame).
- First frame_sync after reset: first cycle after rst deasserts (row 0 slot begins).
- Frame period = ROWS*SLOT cycles; each row lit SLOT-BLANK cycles per frame.
- Reset mid-slot: immediate blank, buffers cleared; any in-flight load lost, no ack.
- Never more than one row_sel bit high; row_sel and col_n change only on slot-phase boundaries (or PWM edges, below).

Optional Feature:
BRIGHTNESS_PWM_EN: adds input port brightness (4 bits). A 4-bit PWM counter resets to 0 at every ON entry and increments each ON cycle (wraps). During ON, columns driven from active[row] only while pwm_cnt <= bright_q, else col_n=all 1s (row_sel stays asserted). bright_q = brightness sampled at ON entry. 15 = full duty, 0 = 1/16 duty. Without macro: no brightness port, full duty during ON.

Test Plan:
Reset: SLOT=8, BLANK=2, assert rst mid-ON -> row_sel=0, col_n=7'h7F same cycle; frame_sync pulses on first cycle after release.
Scan timing: load frame with row r = 7'h01<<r -> row r: 2 cycles blank, 6 cycles row_sel=1<<r, col_n=~(7'h01<<r); frame_sync every 40 cycles.
Tear-free swap: load frame B while row 2 active -> rows 2..4 still show frame A; frame B appears at next row 0; load_ack one cycle after load.
Collision: load frame C exactly on the row4->row0 edge with B pending -> next frame shows B, following frame shows C.
Back-to-back loads D,E on consecutive cycles -> two load_ack pulses; only E displayed.
PWM (macro on, SLOT=40, BLANK=2): brightness=3 -> within each ON phase col_n active for 4 of every 16 cycles; brightness=15 -> active all 38 ON cycles.
